// File: rtl/umi_cmd_encode_if.sv
// umi_cmd_encode_if
//   Bundles the request, packet-output and response-credit signals of the
//   UMI command encoder.
//   Ports (by group):
//     req_*       : request handshake and fields (valid/ready, op, atype,
//                   size, dstaddr, srcaddr, data)
//     out_*       : encoded packet handshake and fields (valid/ready, cmd,
//                   dstaddr, srcaddr, data)
//     resp_done   : one non-posted response retired (one-cycle pulse)
//     outstanding : current count of outstanding non-posted requests
//     err_atype   : pulse, request dropped for an illegal atomic subtype
//   Modports: slave = encoder side, master = requester/consumer side.
interface umi_cmd_encode_if #(
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int MAXOUT = 8
);
    localparam int OW = $clog2(MAXOUT + 1);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [3:0]    req_atype;
    logic [3:0]    req_size;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dstaddr;
    logic [AW-1:0] out_srcaddr;
    logic [DW-1:0] out_data;

    logic          resp_done;
    logic [OW-1:0] outstanding;
    logic          err_atype;

    modport slave (
        input  req_valid, req_op, req_atype, req_size,
               req_dstaddr, req_srcaddr, req_data,
        output req_ready,
        output out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
        input  out_ready,
        input  resp_done,
        output outstanding, err_atype
    );

    modport master (
        output req_valid, req_op, req_atype, req_size,
               req_dstaddr, req_srcaddr, req_data,
        input  req_ready,
        input  out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
        output out_ready,
        output resp_done,
        input  outstanding, err_atype
    );
endinterface

// File: rtl/umi_cmd_encode.sv
// umi_cmd_encode
//   Encodes a request (op, atomic subtype, size, addresses, data) into a UMI
//   command word and buffers the resulting packet in a 2-entry skid FIFO.
//   Tracks outstanding non-posted requests against MAXOUT credits and drops
//   atomics carrying an illegal subtype, flagging them on err_atype.
//   Ports:
//     clk   : single clock, rising edge
//     reset : synchronous active-high reset
//     bus   : umi_cmd_encode_if.slave (request in, packet out, credits)
module umi_cmd_encode #(
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int MAXOUT = 8
) (
    input  logic           clk,
    input  logic           reset,
    umi_cmd_encode_if.slave bus
);
    localparam int OW = $clog2(MAXOUT + 1);

    localparam logic [2:0] OP_POSTED = 3'd2;
    localparam logic [2:0] OP_ATOMIC = 3'd4;
    localparam logic [2:0] OP_LINK   = 3'd7;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } pkt_t;

    // Head register drives the outputs directly; skid holds the second entry.
    pkt_t          out_pkt_reg;
    logic          out_valid_reg;
    pkt_t          skid_pkt_reg;
    logic          skid_valid_reg;
    logic [OW-1:0] outstanding_reg;
    logic          err_atype_reg;

    logic [CW-1:0] cmd_enc;
    pkt_t          new_pkt;
    logic          non_posted;
    logic          atype_bad;
    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;
    logic          inc;
    logic          dec;

    // Opcode nibble is {op,1}: 1,3,5,...,D; LINK overrides the whole low byte.
    // Bit 0 is therefore always set, so an all-zero low byte never leaves.
    always_comb begin
        cmd_enc = '0;
        if (bus.req_op == OP_LINK) begin
            cmd_enc[7:0] = 8'h0F;
        end else begin
            cmd_enc[3:0] = {bus.req_op, 1'b1};
        end
        if (bus.req_op == OP_ATOMIC) begin
            cmd_enc[15:8] = {4'h0, bus.req_atype};
        end
        cmd_enc[19:16] = bus.req_size;
    end

    assign new_pkt = '{cmd: cmd_enc, dst: bus.req_dstaddr,
                       src: bus.req_srcaddr, data: bus.req_data};

    assign non_posted = (bus.req_op != OP_POSTED) && (bus.req_op != OP_LINK);
    assign atype_bad  = (bus.req_op == OP_ATOMIC) && (bus.req_atype > 4'd8);

    // Credits only gate non-posted traffic; posted requests flow regardless.
    assign credit_ok     = !((outstanding_reg == OW'(MAXOUT)) && non_posted);
    assign bus.req_ready = !reset && !(out_valid_reg && skid_valid_reg) && credit_ok;

    assign accept = bus.req_valid && bus.req_ready;
    // An illegal atomic is handshaken normally but never enters the FIFO.
    assign push   = accept && !atype_bad;
    assign pop    = out_valid_reg && bus.out_ready;
    assign inc    = push && non_posted;
    // A response with nothing outstanding is ignored rather than underflowing.
    assign dec    = bus.resp_done && (outstanding_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_pkt_reg     <= '0;
            out_valid_reg   <= 1'b0;
            skid_pkt_reg    <= '0;
            skid_valid_reg  <= 1'b0;
            outstanding_reg <= '0;
            err_atype_reg   <= 1'b0;
        end else begin
            err_atype_reg <= accept && atype_bad;

            if (inc && !dec) begin
                outstanding_reg <= outstanding_reg + OW'(1);
            end else if (dec && !inc) begin
                outstanding_reg <= outstanding_reg - OW'(1);
            end

            // Head slot is free (empty or draining this cycle): refill it from
            // the skid entry first to preserve order, else from the new request.
            // A full FIFO never pushes, so skid and push are exclusive here.
            if (!out_valid_reg || pop) begin
                if (skid_valid_reg) begin
                    out_pkt_reg    <= skid_pkt_reg;
                    out_valid_reg  <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else if (push) begin
                    out_pkt_reg    <= new_pkt;
                    out_valid_reg  <= 1'b1;
                end else begin
                    out_valid_reg  <= 1'b0;
                end
            end else if (push) begin
                skid_pkt_reg   <= new_pkt;
                skid_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_cmd     = out_pkt_reg.cmd;
    assign bus.out_dstaddr = out_pkt_reg.dst;
    assign bus.out_srcaddr = out_pkt_reg.src;
    assign bus.out_data    = out_pkt_reg.data;
    assign bus.outstanding = outstanding_reg;
    assign bus.err_atype   = err_atype_reg;
endmodule

// File: doc/umi_cmd_encode.md
UMI_CMD_ENCODE -- requirements
Module: umi_cmd_encode

Interface
REQ-001 SHALL have parameter CW, default 32, command word width.
REQ-002 SHALL have parameter AW, default 64, address width.
REQ-003 SHALL have parameter DW, default 64, data width.
REQ-004 SHALL have parameter MAXOUT, default 8, maximum outstanding non-posted requests (power of two, 2..256).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid  input  1  request fields valid.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-009 SHALL have port req_op  input  3  0 READ, 1 WRITE, 2 POSTED, 3 RDMA, 4 ATOMIC, 5 USER0, 6 FUTURE0, 7 LINK.
REQ-010 SHALL have port req_atype  input  4  atomic subtype, 0 ADD .. 8 SWAP (ADD, AND, OR, XOR, MAX, MIN, MAXU, MINU, SWAP).
REQ-011 SHALL have port req_size  input  4  transfer size code.
REQ-012 SHALL have ports req_dstaddr/req_srcaddr  input  AW  and req_data  input  DW  payload.
REQ-013 SHALL have port out_valid  output  1  packet valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-015 SHALL have ports out_cmd  output  CW, out_dstaddr/out_srcaddr  output  AW, out_data  output  DW.
REQ-016 SHALL have port resp_done  input  1  one-cycle pulse, one non-posted response retired.
REQ-017 SHALL have port outstanding  output  $clog2(MAXOUT+1)  current outstanding count.
REQ-018 SHALL have port err_atype  output  1  one-cycle pulse, request dropped for illegal atomic subtype.

Function
REQ-019 SHALL encode out_cmd[3:0] as READ 0x1, WRITE 0x3, POSTED 0x5, RDMA 0x7, ATOMIC 0x9, USER0 0xB, FUTURE0 0xD; LINK SHALL set out_cmd[7:0]=0x0F.
REQ-020 SHALL drive out_cmd[7:4]=0 for non-LINK ops; out_cmd[15:8]=req_atype for ATOMIC, else 0; out_cmd[19:16]=req_size; out_cmd[CW-1:20]=0.
REQ-021 SHALL never emit out_cmd[7:0]=0x00 (invalid); every emitted command has bit0=1.
REQ-022 SHALL buffer packets in a 2-entry FIFO (skid): req_ready = ~reset & (entries<2) & credit_ok.
REQ-023 SHALL present an accepted request on outputs the cycle after acceptance (latency 1) when FIFO was empty.
REQ-024 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-025 SHALL sustain one accept and one emit per cycle when out_ready is held high.
REQ-026 SHALL treat READ, WRITE, RDMA, ATOMIC, USER0, FUTURE0 as non-posted; POSTED and LINK as posted.
REQ-027 SHALL increment outstanding on acceptance of a non-posted request and decrement on resp_done; simultaneous events leave it unchanged.
REQ-028 SHALL set credit_ok=0 when outstanding==MAXOUT and the presented request is non-posted; posted requests are unaffected.
REQ-029 SHALL ignore resp_done when outstanding==0 (no underflow).
REQ-030 SHALL, for ATOMIC with req_atype>8, assert req_ready normally, drop the request, not change outstanding, and pulse err_atype the following cycle.
REQ-031 SHALL sample payload only on the accepting edge; changes to req_* while ~req_ready have no effect.

Reset
REQ-032 SHALL, while reset is high, drive req_ready=0, out_valid=0, err_atype=0, outstanding=0, and flush the FIFO.
REQ-033 SHALL drive out_cmd, out_dstaddr, out_srcaddr, out_data to 0 during reset.
REQ-034 SHALL discard in-flight packets on reset asserted mid-transfer; first post-reset accept occurs no earlier than the cycle after reset deasserts.

Verification
REQ-035 SHALL verify: READ, size 3, dst 0x1000, out_ready=1 -> out_cmd=0x00030001 one cycle later, outstanding=1.
REQ-036 SHALL verify: ATOMIC atype 8 (SWAP) -> out_cmd=0x00000809; ATOMIC atype 9 -> no packet, err_atype pulse, outstanding unchanged.
REQ-037 SHALL verify: out_ready=0, three back-to-back requests -> two accepted, req_ready low on third, packets later emitted in order unchanged.
REQ-038 SHALL verify: MAXOUT=8, eight READs with no resp_done -> ninth READ stalls, POSTED still accepted; one resp_done -> READ accepted next cycle.
REQ-039 SHALL verify: accept non-posted plus resp_done same cycle at outstanding=4 -> stays 4; resp_done at 0 -> stays 0.
REQ-040 SHALL verify: reset asserted with 2 entries buffered -> out_valid=0 next cycle, outstanding=0, nothing emitted after release.
